// File: rtl/saratoga_pkg.sv
// Shared trap-sequencer types: FSM state encoding, trap record layout and the
// interrupt bit position of mcause at the default datapath width.
package saratoga;

  localparam int TRAP_XLEN_DEF      = 32;
  localparam int TRAP_CAUSE_INT_BIT = TRAP_XLEN_DEF - 1;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } trap_state_e;

  // Record layout at the default width; trap_ctrl mirrors it at its own XLEN.
  typedef struct packed {
    logic                     is_mret;
    logic [TRAP_XLEN_DEF-1:0] epc;
    logic [TRAP_XLEN_DEF-1:0] cause;
    logic [TRAP_XLEN_DEF-1:0] val;
  } trap_rec_t;

endpackage

// File: rtl/trap_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder; idx is 0 when no request is set.
module trap_prio_enc #(
  parameter  int W  = 32,
  localparam int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: picks the oldest exception/MRET (else lowest pending interrupt),
// registers it and holds trap_req until trap_ack. Vectored mode: TRAP_VECTORED_EN.
module trap_ctrl
  import saratoga::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_STAGES = 3,
  parameter int NUM_IRQ    = 32,
  parameter int CAUSE_W    = 5,
  parameter int MRET_STAGE = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_STAGES*XLEN-1:0]    stage_pc,
  input  logic [NUM_STAGES-1:0]         stage_bubble,
  input  logic [NUM_STAGES-1:0]         exc_flag,
  input  logic [NUM_STAGES*CAUSE_W-1:0] exc_cause,
  input  logic [NUM_STAGES*XLEN-1:0]    exc_val,
  input  logic                          mret,
  input  logic [NUM_IRQ-1:0]            interrupts,
  input  logic [XLEN-1:0]               mepc,
  input  logic [XLEN-1:0]               mtvec,
  output logic                          trap_req,
  input  logic                          trap_ack,
  output logic                          trap_is_mret,
  output logic [XLEN-1:0]               trap_addr,
  output logic [XLEN-1:0]               trap_epc,
  output logic [XLEN-1:0]               trap_cause,
  output logic [XLEN-1:0]               trap_val,
  output logic [NUM_STAGES-1:0]         squash
);

  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef struct packed {
    logic            is_mret;
    logic [XLEN-1:0] epc;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] val;
  } rec_t;

  trap_state_e           state_reg;
  rec_t                  rec_reg, rec_next;
  logic [NUM_STAGES-1:0] stage_cand, stage_cand_rev;
  logic                  stage_hit, irq_hit;
  logic [SW-1:0]         stage_rev_idx, win_stage;
  logic [IW-1:0]         irq_idx;
  logic [XLEN-1:0]       trap_base, vec_off;
  logic                  unused_mode;

  // Stage vector is reversed so the shared lowest-index encoder finds the oldest stage.
  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_cand
      assign stage_cand[gi] = !stage_bubble[gi] &&
                              (exc_flag[gi] || ((gi == MRET_STAGE) && mret));
      assign stage_cand_rev[gi] = stage_cand[NUM_STAGES-1-gi];
    end
  endgenerate

  trap_prio_enc #(.W(NUM_STAGES)) u_stage_enc (
    .req   (stage_cand_rev),
    .valid (stage_hit),
    .idx   (stage_rev_idx)
  );

  trap_prio_enc #(.W(NUM_IRQ)) u_irq_enc (
    .req   (interrupts),
    .valid (irq_hit),
    .idx   (irq_idx)
  );

  assign win_stage = SW'(NUM_STAGES - 1) - stage_rev_idx;

  always_comb begin
    rec_next = '0;
    if (stage_hit) begin
      rec_next.epc = stage_pc[win_stage*XLEN +: XLEN];
      if (exc_flag[win_stage]) begin
        rec_next.cause = XLEN'(exc_cause[win_stage*CAUSE_W +: CAUSE_W]);
        rec_next.val   = exc_val[win_stage*XLEN +: XLEN];
      end else begin
        rec_next.is_mret = 1'b1;
      end
    end else if (irq_hit) begin
      rec_next.cause[XLEN-1] = 1'b1;
      rec_next.cause[IW-1:0] = irq_idx;
      rec_next.epc           = stage_pc[XLEN-1:0];
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_squash
      assign squash[gi] = (state_reg == IDLE) && stage_hit && (SW'(gi) <= win_stage);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      rec_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (stage_hit || irq_hit) begin
            rec_reg   <= rec_next;
            state_reg <= PENDING;
          end
        end
        PENDING: begin
          if (trap_ack) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign trap_base   = {mtvec[XLEN-1:2], 2'b00};
  assign unused_mode = ^mtvec[1:0];

  always_comb begin
    vec_off = '0;
`ifdef TRAP_VECTORED_EN
    // The interrupt index sits in the low cause bits, so the offset is cause<<2.
    if ((mtvec[1:0] == 2'b01) && rec_reg.cause[XLEN-1])
      vec_off = {rec_reg.cause[XLEN-3:0], 2'b00};
`endif
  end

  always_comb begin
    trap_addr = '0;
    if (state_reg == PENDING)
      trap_addr = rec_reg.is_mret ? mepc : trap_base + vec_off;
  end

  assign trap_req     = (state_reg == PENDING);
  assign trap_is_mret = rec_reg.is_mret;
  assign trap_epc     = rec_reg.epc;
  assign trap_cause   = rec_reg.cause;
  assign trap_val     = rec_reg.val;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed plus randomized bench for trap_ctrl against a behavioural trap model.
module tb_trap_ctrl;

  localparam int XLEN = 32;
  localparam int NS   = 3;
  localparam int NIRQ = 32;
  localparam int CW   = 5;
  localparam int MS   = 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NS*XLEN-1:0]   stage_pc, exc_val;
  logic [NS-1:0]        stage_bubble, exc_flag;
  logic [NS*CW-1:0]     exc_cause;
  logic                 mret;
  logic [NIRQ-1:0]      interrupts;
  logic [XLEN-1:0]      mepc, mtvec;
  logic                 trap_ack;
  logic                 trap_req, trap_is_mret;
  logic [XLEN-1:0]      trap_addr, trap_epc, trap_cause, trap_val;
  logic [NS-1:0]        squash;

  int checks = 0;
  int errors = 0;

  logic        m_pend, m_mret;
  logic [31:0] m_epc, m_cause, m_val;

  trap_ctrl #(
    .XLEN(XLEN), .NUM_STAGES(NS), .NUM_IRQ(NIRQ), .CAUSE_W(CW), .MRET_STAGE(MS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stage_pc     (stage_pc),
    .stage_bubble (stage_bubble),
    .exc_flag     (exc_flag),
    .exc_cause    (exc_cause),
    .exc_val      (exc_val),
    .mret         (mret),
    .interrupts   (interrupts),
    .mepc         (mepc),
    .mtvec        (mtvec),
    .trap_req     (trap_req),
    .trap_ack     (trap_ack),
    .trap_is_mret (trap_is_mret),
    .trap_addr    (trap_addr),
    .trap_epc     (trap_epc),
    .trap_cause   (trap_cause),
    .trap_val     (trap_val),
    .squash       (squash)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Oldest live stage wins; exception beats MRET; interrupts only when no stage traps.
  task automatic model_pick(output logic found, output logic is_m, output logic [31:0] epc,
                            output logic [31:0] cause, output logic [31:0] val,
                            output logic [NS-1:0] sq);
    found = 0; is_m = 0; epc = 0; cause = 0; val = 0; sq = '0;
    for (int s = NS - 1; s >= 0; s--) begin
      if (!found && !stage_bubble[s] && (exc_flag[s] || (s == MS && mret))) begin
        found = 1;
        for (int i = 0; i <= s; i++) sq[i] = 1'b1;
        epc = stage_pc[s*XLEN +: XLEN];
        if (exc_flag[s]) begin
          cause = 32'(exc_cause[s*CW +: CW]);
          val   = exc_val[s*XLEN +: XLEN];
        end else begin
          is_m = 1;
        end
      end
    end
    for (int k = 0; k < NIRQ; k++) begin
      if (!found && interrupts[k]) begin
        found = 1;
        cause = 32'h8000_0000 | 32'(k);
        epc   = stage_pc[XLEN-1:0];
      end
    end
  endtask

  function automatic logic [31:0] model_addr();
    logic [31:0] addr;
    if (!m_pend) return 32'h0;
    if (m_mret) return mepc;
    addr = mtvec & 32'hFFFF_FFFC;
`ifdef TRAP_VECTORED_EN
    if (mtvec[1:0] == 2'b01 && m_cause[31]) addr = addr + (m_cause & 32'h7FFF_FFFF) * 4;
`endif
    return addr;
  endfunction

  // Entered just after a rising edge with inputs already applied.
  task automatic cycle(input string tag);
    logic found, is_m;
    logic [31:0] e, c, v;
    logic [NS-1:0] sq;
    model_pick(found, is_m, e, c, v, sq);
    #2;
    if (rst_n) chk({tag, ".squash"}, XLEN'(squash), (m_pend || !found) ? '0 : XLEN'(sq));
    @(posedge clk);
    if (!rst_n) begin
      m_pend = 0; m_mret = 0; m_epc = 0; m_cause = 0; m_val = 0;
    end else if (m_pend) begin
      if (trap_ack) m_pend = 0;
    end else if (found) begin
      m_pend = 1; m_mret = is_m; m_epc = e; m_cause = c; m_val = v;
      $display("capture %s t=%0t mret=%0d epc=0x%0h cause=0x%0h val=0x%0h",
               tag, $time, is_m, e, c, v);
    end
    #1;
    chk({tag, ".req"},   XLEN'(trap_req),     XLEN'(m_pend));
    chk({tag, ".mret"},  XLEN'(trap_is_mret), XLEN'(m_mret));
    chk({tag, ".epc"},   trap_epc,   m_epc);
    chk({tag, ".cause"}, trap_cause, m_cause);
    chk({tag, ".val"},   trap_val,   m_val);
    chk({tag, ".addr"},  trap_addr,  model_addr());
  endtask

  task automatic clear_flags();
    exc_flag = '0; exc_cause = '0; exc_val = '0; stage_bubble = '0;
    mret = 0; interrupts = '0; trap_ack = 0;
  endtask

  initial begin
    m_pend = 0; m_mret = 0; m_epc = 0; m_cause = 0; m_val = 0;
    clear_flags();
    stage_pc = {32'h300, 32'h100, 32'h40};
    mepc  = 32'h0;
    mtvec = 32'h8000;
    rst_n = 0;
    @(posedge clk); #1;
    cycle("rst");
    rst_n = 1;

    // Single exception in stage 1
    exc_flag = 3'b010; exc_cause[1*CW +: CW] = 5'd2; exc_val[1*XLEN +: XLEN] = 32'h13;
    cycle("t1");
    chk("t1.cause_const", trap_cause, 32'd2);
    chk("t1.addr_const",  trap_addr,  32'h8000);
    clear_flags(); trap_ack = 1;
    cycle("t1ack");
    trap_ack = 0;

    // Oldest stage wins
    exc_flag = 3'b110; exc_cause[2*CW +: CW] = 5'd6; exc_cause[1*CW +: CW] = 5'd2;
    cycle("t2");
    chk("t2.cause_const", trap_cause, 32'd6);
    chk("t2.epc_const",   trap_epc,   32'h300);
    clear_flags(); trap_ack = 1;
    cycle("t2ack");
    trap_ack = 0;

    // Interrupt selection and vectoring
    interrupts = (32'h1 << 3) | (32'h1 << 7); mtvec = 32'h8001;
    cycle("t3");
    chk("t3.cause_const", trap_cause, 32'h8000_0003);
    chk("t3.epc_const",   trap_epc,   32'h40);
`ifdef TRAP_VECTORED_EN
    chk("t3.addr_const",  trap_addr,  32'h800C);
`else
    chk("t3.addr_const",  trap_addr,  32'h8000);
`endif
    clear_flags(); trap_ack = 1;
    cycle("t3ack");
    trap_ack = 0;

    // MRET, then MRET colliding with an exception in the same stage
    mret = 1; mepc = 32'h240;
    cycle("t4");
    chk("t4.mret_const", XLEN'(trap_is_mret), 32'd1);
    chk("t4.addr_const", trap_addr, 32'h240);
    clear_flags(); trap_ack = 1;
    cycle("t4ack");
    clear_flags();
    mret = 1; exc_flag = 3'b010; exc_cause[1*CW +: CW] = 5'd2;
    cycle("t4b");
    chk("t4b.mret_const", XLEN'(trap_is_mret), 32'd0);
    clear_flags(); trap_ack = 1;
    cycle("t4back");
    trap_ack = 0;

    // Record held while ack is low and flags toggle
    exc_flag = 3'b001; exc_cause[0 +: CW] = 5'd4;
    cycle("t5");
    for (int i = 0; i < 5; i++) begin
      exc_flag = NS'($urandom_range(0, 7)); exc_cause = NS*CW'($urandom);
      interrupts = $urandom; mret = 1'($urandom);
      cycle("t5hold");
      chk("t5.hold_cause", trap_cause, 32'd4);
      chk("t5.hold_epc",   trap_epc,   32'h40);
    end
    clear_flags();
    exc_flag = 3'b100; exc_cause[2*CW +: CW] = 5'd5; trap_ack = 1;
    cycle("t5ack");
    chk("t5.ack_req", XLEN'(trap_req), 32'd0);
    trap_ack = 0;
    cycle("t5new");
    chk("t5.new_cause", trap_cause, 32'd5);

    // Reset while pending, then all-bubble stages
    rst_n = 0;
    cycle("t6rst");
    chk("t6.req_zero",   XLEN'(trap_req), 32'd0);
    chk("t6.cause_zero", trap_cause, 32'd0);
    chk("t6.addr_zero",  trap_addr,  32'd0);
    rst_n = 1;
    clear_flags();
    stage_bubble = 3'b111; exc_flag = 3'b111; mret = 1;
    cycle("t6bub");
    chk("t6.bub_req", XLEN'(trap_req), 32'd0);
    cycle("t6bub2");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      clear_flags();
      for (int s = 0; s < NS; s++) begin
        exc_flag[s]     = ($urandom_range(0, 5) == 0);
        stage_bubble[s] = ($urandom_range(0, 4) == 0);
      end
      exc_cause = NS*CW'($urandom);
      exc_val   = {$urandom, $urandom, $urandom};
      stage_pc  = {$urandom, $urandom, $urandom};
      mret      = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1) == 1)
        interrupts = (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31));
      mepc     = $urandom;
      mtvec    = $urandom;
      trap_ack = ($urandom_range(0, 2) == 0);
      rst_n    = ($urandom_range(0, 60) != 0);
      cycle("rnd");
      rst_n = 1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Parametrised trap sequencer for the in-order core.
- Collects per-stage exceptions, MRET and masked interrupts, and selects one trap (oldest instruction wins).
- Registers the trap record and holds a req/ack handshake with the Control Unit until the trap is inserted.
- Drives per-stage squash and computes the trap destination; supports any pipeline depth and interrupt count.

Parameters:
- XLEN, 32, datapath/CSR width.
- NUM_STAGES, 3, pipeline stages; index 0 = youngest (fetch), NUM_STAGES-1 = oldest.
- NUM_IRQ, 32, interrupt lines (1..XLEN).
- CAUSE_W, 5, exception cause code width.
- MRET_STAGE, 1, stage in which MRET is reported.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- stage_pc  in  NUM_STAGES*XLEN  PC per stage, stage i at [i*XLEN +: XLEN]
- stage_bubble  in  NUM_STAGES  stage holds a bubble; its flags are ignored
- exc_flag  in  NUM_STAGES  exception raised in stage i
- exc_cause  in  NUM_STAGES*CAUSE_W  cause code per stage
- exc_val  in  NUM_STAGES*XLEN  mtval candidate per stage
- mret  in  1  MRET valid in MRET_STAGE
- interrupts  in  NUM_IRQ  pending interrupts, enables already applied
- mepc  in  XLEN  mepc CSR
- mtvec  in  XLEN  mtvec CSR
- trap_req  out  1  trap pending to Control Unit
- trap_ack  in  1  Control Unit inserted the trap
- trap_is_mret  out  1  record is an MRET return
- trap_addr  out  XLEN  redirect target
- trap_epc  out  XLEN  faulting or interrupted PC
- trap_cause  out  XLEN  mcause value
- trap_val  out  XLEN  mtval value
- squash  out  NUM_STAGES  kill instruction in stage i

Behaviour:
- Reset: all outputs 0; FSM in IDLE; record registers cleared. Reset mid-PENDING drops the pending trap.
- FSM states:
  - IDLE: evaluate candidate every cycle. On candidate: capture record at the clock edge, go to PENDING; trap_req=1 from the next cycle (1-cycle latency).
  - PENDING: trap_req held at 1; record frozen; new flags ignored. On trap_ack: go to IDLE, trap_req=0 next cycle; earliest new capture is the cycle after return to IDLE.
  - trap_ack in IDLE is ignored.
- Candidate selection (IDLE only):
  - Stage s is a candidate if exc_flag[s] & !stage_bubble[s]. MRET counts as a candidate at MRET_STAGE if mret & !stage_bubble[MRET_STAGE].
  - The highest-index candidate stage wins. At the same stage, exception beats MRET.
  - Interrupts are taken only if no exception or MRET candidate exists.
- Record contents:
  - Exception: epc=stage_pc[s]; cause=zero-extended exc_cause[s]; val=exc_val[s]; is_mret=0.
  - MRET: is_mret=1; epc=stage_pc[MRET_STAGE]; cause=0; val=0.
  - Interrupt: lowest set index k wins; cause={1'b1, k zero-extended to XLEN-1 bits}; epc=stage_pc[0]; val=0.
- squash is combinational, IDLE only:
  - Exception/MRET winner at stage s: squash[i]=1 for all i<=s.
  - Interrupt: squash all 0.
  - PENDING: squash all 0.
- trap_addr is combinational from the registered record:
  - is_mret: mepc.
  - Otherwise: base={mtvec[XLEN-1:2],2'b00}.
  - Vectored interrupt (see Optional Feature): base + (k<<2), modulo 2^XLEN.

Optional Feature:
- Macro: TRAP_VECTORED_EN.
- Defined: mtvec[1:0]==2'b01 with an interrupt record gives base+4*k. Mode 2'b00 is direct. Exceptions are always direct.
- Undefined: mtvec[1:0] is ignored and every non-MRET trap goes to base.

Decomposition:
- Shared package saratoga: trap_state_e (IDLE, PENDING), trap_rec_t struct (is_mret, epc, cause, val), TRAP_CAUSE_INT_BIT=XLEN-1.
- Exception codes stay in rv32.
- One sub-module, trap_prio_enc: parametrised lowest-index priority encoder, reused for interrupt selection; stage selection uses the same encoder on reversed vectors.

Test Plan:
- exc_flag=3'b010, cause=2, pc1=0x100, val=0x13, mtvec=0x8000 -> cycle+1: trap_req=1, epc=0x100, cause=2, val=0x13, trap_addr=0x8000; squash=3'b011 in the detect cycle.
- exc_flag=3'b110 (stage2 cause=6, stage1 cause=2) -> stage2 wins: cause=6, epc=stage_pc[2], squash=3'b111.
- interrupts=bit3|bit7, mtvec=0x8001, TRAP_VECTORED_EN defined -> cause=0x80000003, epc=stage_pc[0], trap_addr=0x800C; squash=0. Same stimulus with the macro undefined -> trap_addr=0x8000.
- mret=1, mepc=0x240 -> trap_is_mret=1, trap_addr=0x240. mret together with exc_flag[MRET_STAGE] -> exception record wins.
- Hold trap_ack=0 for 5 cycles while flags toggle -> trap_req and record unchanged. Ack -> trap_req=0 next cycle, new capture the cycle after.
- Assert rst_n=0 while PENDING -> next cycle all outputs 0 and FSM in IDLE. stage_bubble=3'b111 with all flags set and interrupts=0 -> no trap.
